// File: rtl/branch_resolve_if.sv
// Redirect handshake between the branch resolution unit and fetch.
// The resolver is the master: it requests a redirect and fetch answers with ready.
interface branch_resolve_if;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush_front;

  modport master (
    output redirect_valid,
    output redirect_pc,
    output flush_front,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    input  flush_front,
    output redirect_ready
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: carries branches D->E->M, detects mispredicts in M, and
// holds a redirect request to fetch until it is accepted. Keeps branch stats.
module branch_resolve #(
  parameter int          CNT_W  = 32,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallE,
  input  logic              stallM,
  input  logic              flushE,
  input  logic              flushM,
  input  logic              branchD,
  input  logic              pred_takeD,
  input  logic [31:0]       pcD,
  input  logic              actual_takeE,
  input  logic [31:0]       targetE,
  output logic [31:0]       pcM,
  output logic              branchM,
  output logic              actual_takeM,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt,
  branch_resolve_if.master  redir
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      nextState;

  logic        branchE;
  logic        predTakeE;
  logic [31:0] pcE;

  logic        branchRegM;
  logic        predTakeM;
  logic        actualTakeRegM;
  logic [31:0] pcRegM;
  logic [31:0] targetM;

  logic [31:0] holdPc;
  logic [31:0] correctPc;
  logic        inIdle;
  logic        mispredM;
  logic        countBranch;
  logic        redirValid;
  logic [31:0] redirPc;
  logic        latchHold;

  // D->E pipeline register; flush takes priority over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchE   <= 1'b0;
      predTakeE <= 1'b0;
      pcE       <= 32'h0000_0000;
    end else if (flushE) begin
      branchE   <= 1'b0;
      predTakeE <= 1'b0;
    end else if (!stallE) begin
      branchE   <= branchD;
      predTakeE <= pred_takeD;
      pcE       <= pcD;
    end
  end

  // E->M pipeline register; captures the resolved direction and target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchRegM     <= 1'b0;
      predTakeM      <= 1'b0;
      actualTakeRegM <= 1'b0;
      pcRegM         <= 32'h0000_0000;
      targetM        <= 32'h0000_0000;
    end else if (flushM) begin
      branchRegM     <= 1'b0;
      predTakeM      <= 1'b0;
    end else if (!stallM) begin
      branchRegM     <= branchE;
      predTakeM      <= predTakeE;
      actualTakeRegM <= actual_takeE;
      pcRegM         <= pcE;
      targetM        <= targetE;
    end
  end

  assign pcM          = pcRegM;
  assign actual_takeM = actualTakeRegM;
  assign branchM      = branchRegM & ~stallM;

  // While a redirect is pending every new branch in M is ignored
  assign inIdle      = (state == IDLE);
  assign mispredM    = branchM & (predTakeM ^ actualTakeRegM) & inIdle;
  assign countBranch = branchM & inIdle;
  assign correctPc   = actualTakeRegM ? targetM : (pcRegM + 32'd4);

  // Redirect FSM next-state and request outputs
  always_comb begin
    nextState  = state;
    redirValid = 1'b0;
    redirPc    = holdPc;
    latchHold  = 1'b0;
    case (state)
      IDLE: begin
        if (mispredM) begin
          redirValid = 1'b1;
          redirPc    = correctPc;
          latchHold  = 1'b1;
          if (redir.redirect_ready) begin
            nextState = IDLE;
          end else begin
            nextState = HOLD;
          end
        end else begin
          redirValid = 1'b0;
          redirPc    = holdPc;
        end
      end
      HOLD: begin
        redirValid = 1'b1;
        redirPc    = holdPc;
        if (redir.redirect_ready) begin
          nextState = IDLE;
        end else begin
          nextState = HOLD;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign redir.redirect_valid = redirValid;
  assign redir.redirect_pc    = redirPc;
  assign redir.flush_front    = redirValid;

  // State register and the last driven redirect PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      holdPc <= RST_PC;
    end else begin
      state <= nextState;
      if (latchHold) begin
        holdPc <= correctPc;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= {CNT_W{1'b0}};
      mispred_cnt <= {CNT_W{1'b0}};
    end else begin
      if (countBranch && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + CNT_ONE;
      end
      if (mispredM && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (4-bit counters, RST_PC=0x1000).
`timescale 1ns/1ps
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallE, stallM, flushE, flushM;
  logic        branchD, pred_takeD, actual_takeE;
  logic [31:0] pcD, targetE;
  logic [31:0] pcM;
  logic        branchM, actual_takeM;
  logic [3:0]  branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_if rif ();

  branch_resolve #(.CNT_W(4), .RST_PC(32'h0000_1000)) dut (
    .clk(clk), .rst(rst),
    .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushM(flushM),
    .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
    .actual_takeE(actual_takeE), .targetE(targetE),
    .pcM(pcM), .branchM(branchM), .actual_takeM(actual_takeM),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .redir(rif.master)
  );

  task automatic idle_inputs();
    stallE = 1'b0; stallM = 1'b0; flushE = 1'b0; flushM = 1'b0;
    branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'h0;
    actual_takeE = 1'b0; targetE = 32'h0;
    rif.redirect_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    checks++; if (rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", rif.redirect_valid); end
    checks++; if (rif.flush_front !== 1'b0) begin errors++; $display("FAIL reset_flush got %0h exp 0", rif.flush_front); end
    checks++; if (branchM !== 1'b0) begin errors++; $display("FAIL reset_branchM got %0h exp 0", branchM); end
    checks++; if (rif.redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL reset_pc got %h exp 00001000", rif.redirect_pc); end
    checks++; if (pcM !== 32'h0) begin errors++; $display("FAIL reset_pcM got %h exp 0", pcM); end
    checks++; if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_correct();
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h100;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'h0;
    actual_takeE = 1'b1; targetE = 32'h200;
    tick();
    actual_takeE = 1'b0; targetE = 32'h0;
    #1;
    checks++; if (branchM !== 1'b1) begin errors++; $display("FAIL correct_branchM got %0h exp 1", branchM); end
    checks++; if (pcM !== 32'h100) begin errors++; $display("FAIL correct_pcM got %h exp 00000100", pcM); end
    checks++; if (actual_takeM !== 1'b1) begin errors++; $display("FAIL correct_actual got %0h exp 1", actual_takeM); end
    checks++; if (rif.redirect_valid !== 1'b0 || rif.flush_front !== 1'b0) begin errors++; $display("FAIL correct_noredir got %0h/%0h exp 0/0", rif.redirect_valid, rif.flush_front); end
    tick();
    checks++; if (branch_cnt !== 4'h1 || mispred_cnt !== 4'h0) begin errors++; $display("FAIL correct_cnt got %h/%h exp 1/0", branch_cnt, mispred_cnt); end
    checks++; if (branchM !== 1'b0) begin errors++; $display("FAIL correct_after got %0h exp 0", branchM); end
  endtask

  task automatic test_mispredict_nt();
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h100;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'h0;
    actual_takeE = 1'b0; targetE = 32'h200;
    tick();
    #1;
    checks++; if (rif.redirect_valid !== 1'b1 || rif.flush_front !== 1'b1) begin errors++; $display("FAIL nt_redir got %0h/%0h exp 1/1", rif.redirect_valid, rif.flush_front); end
    checks++; if (rif.redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_pc got %h exp 00000104", rif.redirect_pc); end
    tick();
    checks++; if (rif.redirect_valid !== 1'b0 || rif.flush_front !== 1'b0) begin errors++; $display("FAIL nt_oneshot got %0h/%0h exp 0/0", rif.redirect_valid, rif.flush_front); end
    checks++; if (rif.redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_lastpc got %h exp 00000104", rif.redirect_pc); end
    checks++; if (mispred_cnt !== 4'h1 || branch_cnt !== 4'h1) begin errors++; $display("FAIL nt_cnt got %h/%h exp 1/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b0; pcD = 32'h300;
    tick();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h500;
    actual_takeE = 1'b1; targetE = 32'h400;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'h0;
    actual_takeE = 1'b0; targetE = 32'h999;
    rif.redirect_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rif.redirect_ready = 1'b1;
      #1;
      checks++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h400) begin errors++; $display("FAIL bp_hold%0d got %0h/%h exp 1/00000400", c, rif.redirect_valid, rif.redirect_pc); end
      if (c == 1) begin
        checks++; if (mispred_cnt !== 4'h1 || branch_cnt !== 4'h1) begin errors++; $display("FAIL bp_midcnt got %h/%h exp 1/1", branch_cnt, mispred_cnt); end
      end
      tick();
    end
    checks++; if (rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %0h exp 0", rif.redirect_valid); end
    checks++; if (mispred_cnt !== 4'h1 || branch_cnt !== 4'h1) begin errors++; $display("FAIL bp_cnt got %h/%h exp 1/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_flush_stall();
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h600; flushE = 1'b1;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; flushE = 1'b0; actual_takeE = 1'b0;
    tick();
    #1;
    checks++; if (branchM !== 1'b0 || rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL flushE got %0h/%0h exp 0/0", branchM, rif.redirect_valid); end
    tick();
    branchD = 1'b1; pred_takeD = 1'b0; pcD = 32'h680;
    tick();
    branchD = 1'b0; actual_takeE = 1'b1; targetE = 32'h700;
    tick();
    actual_takeE = 1'b0; targetE = 32'h0;
    stallM = 1'b1; stallE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (branchM !== 1'b0 || rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL stall%0d got %0h/%0h exp 0/0", c, branchM, rif.redirect_valid); end
      tick();
    end
    stallM = 1'b0; stallE = 1'b0;
    #1;
    checks++; if (branchM !== 1'b1 || rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h700) begin errors++; $display("FAIL stall_eval got %0h/%0h/%h exp 1/1/00000700", branchM, rif.redirect_valid, rif.redirect_pc); end
    tick();
    checks++; if (branch_cnt !== 4'h1 || mispred_cnt !== 4'h1) begin errors++; $display("FAIL stall_cnt got %h/%h exp 1/1", branch_cnt, mispred_cnt); end
    // flushM together with stallM drops both the M and the incoming E branch
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h800;
    tick();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h900;
    actual_takeE = 1'b1; targetE = 32'h880;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; actual_takeE = 1'b0;
    flushM = 1'b1; stallM = 1'b1;
    tick();
    flushM = 1'b0; stallM = 1'b0;
    #1;
    checks++; if (branchM !== 1'b0 || rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL flushM got %0h/%0h exp 0/0", branchM, rif.redirect_valid); end
    tick();
    checks++; if (branch_cnt !== 4'h1 || mispred_cnt !== 4'h1) begin errors++; $display("FAIL flushM_cnt got %h/%h exp 1/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b0; pcD = 32'hA00;
    tick();
    branchD = 1'b0; actual_takeE = 1'b1; targetE = 32'hB00;
    tick();
    actual_takeE = 1'b0; rif.redirect_ready = 1'b0;
    tick();
    checks++; if (rif.redirect_valid !== 1'b1 || mispred_cnt !== 4'h1) begin errors++; $display("FAIL ar_hold got %0h/%h exp 1/1", rif.redirect_valid, mispred_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rif.redirect_valid !== 1'b0 || rif.flush_front !== 1'b0) begin errors++; $display("FAIL ar_drop got %0h/%0h exp 0/0", rif.redirect_valid, rif.flush_front); end
    checks++; if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin errors++; $display("FAIL ar_cnt got %h/%h exp 0/0", branch_cnt, mispred_cnt); end
    checks++; if (rif.redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL ar_pc got %h exp 00001000", rif.redirect_pc); end
    #1 rst = 1'b0;
    tick();
    checks++; if (rif.redirect_valid !== 1'b0) begin errors++; $display("FAIL ar_idle got %0h exp 0", rif.redirect_valid); end
  endtask

  task automatic test_saturation_wrap();
    reset_dut();
    for (int i = 0; i < 22; i++) begin
      branchD = (i < 17) ? 1'b1 : 1'b0;
      pred_takeD = 1'b1; pcD = 32'h40; actual_takeE = 1'b0;
      tick();
      if (i == 6) begin
        checks++; if (branch_cnt !== 4'h5 || mispred_cnt !== 4'h5) begin errors++; $display("FAIL sat_mid got %h/%h exp 5/5", branch_cnt, mispred_cnt); end
      end
    end
    checks++; if (branch_cnt !== 4'hF || mispred_cnt !== 4'hF) begin errors++; $display("FAIL sat_end got %h/%h exp f/f", branch_cnt, mispred_cnt); end
    reset_dut();
    branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'hFFFF_FFFC;
    tick();
    branchD = 1'b0; pred_takeD = 1'b0; actual_takeE = 1'b0; targetE = 32'h1234;
    tick();
    #1;
    checks++; if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap got %0h/%h exp 1/00000000", rif.redirect_valid, rif.redirect_pc); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict_nt();
    test_backpressure();
    test_flush_stall();
    test_async_reset();
    test_saturation_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
